// File: rtl/ctx_switch_if.sv
// Context-switch bus: scheduler request/response plus register-file ports.
// The master side is the scheduler/register-file environment; the slave
// side is the context-switch sequencer.
interface ctx_switch_if #(
   parameter int NUM_THREADS = 4,
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 32
);
   localparam int TID_W = $clog2(NUM_THREADS);
   localparam int RA_W  = $clog2(NUM_REGS);

   // scheduler request / response
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_save;
   logic [TID_W-1:0]       req_save_tid;
   logic                   req_restore;
   logic [TID_W-1:0]       req_restore_tid;
   logic                   done;
   logic                   err;
   logic                   busy;
   logic [NUM_THREADS-1:0] ctx_valid;

   // register file ports
   logic [RA_W-1:0]        rf_rd_addr;
   logic [DATA_W-1:0]      rf_rd_data;
   logic                   rf_wr_en;
   logic [RA_W-1:0]        rf_wr_addr;
   logic [DATA_W-1:0]      rf_wr_data;

   modport master (
      output req_valid, req_save, req_save_tid, req_restore, req_restore_tid,
      output rf_rd_data,
      input  req_ready, done, err, busy, ctx_valid,
      input  rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
   );

   modport slave (
      input  req_valid, req_save, req_save_tid, req_restore, req_restore_tid,
      input  rf_rd_data,
      output req_ready, done, err, busy, ctx_valid,
      output rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data
   );
endinterface

// File: rtl/ctx_switch_ctrl.sv
// Thread context-switch sequencer. Streams the active register file into a
// per-thread context slot (SAVE), then streams a saved slot back into the
// register file (RESTORE). Owns the context store and per-slot valid bits.
module ctx_switch_ctrl #(
   parameter int NUM_THREADS = 4,
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 32
) (
   input  logic          clk,
   input  logic          rst,
   ctx_switch_if.slave   bus
);
   localparam int TID_W = $clog2(NUM_THREADS);
   localparam int RA_W  = $clog2(NUM_REGS);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SAVE    = 2'd1;
   localparam logic [1:0] S_RESTORE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   // SAVE runs one extra cycle to absorb the register-file read latency
   localparam logic [RA_W:0] CNT_SAVE_LAST    = (RA_W+1)'(NUM_REGS);
   localparam logic [RA_W:0] CNT_RESTORE_LAST = (RA_W+1)'(NUM_REGS - 1);

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [RA_W:0]          cnt;

   logic                   restore_q;
   logic [TID_W-1:0]       save_tid_q;
   logic [TID_W-1:0]       restore_tid_q;
   logic                   err_q;
   logic [NUM_THREADS-1:0] ctx_valid_q;

   logic [DATA_W-1:0]      store [NUM_THREADS][NUM_REGS];

   logic                   accept;
   logic                   restore_ok;
   logic                   save_last;
   logic                   save_wr;
   logic [RA_W-1:0]        save_idx;
   logic [RA_W-1:0]        cnt_lo;
   logic                   wr_active;

   assign accept     = bus.req_valid && (state == S_IDLE);
   assign restore_ok = ctx_valid_q[restore_tid_q];
   assign cnt_lo     = cnt[RA_W-1:0];
   assign save_last  = (state == S_SAVE) && (cnt == CNT_SAVE_LAST);
   // read data lags the address by one cycle, so cnt k writes word k-1
   assign save_wr    = (state == S_SAVE) && (cnt != '0);
   assign save_idx   = cnt_lo - RA_W'(1);
   // validity cannot change while restoring, so it gates every write cycle
   assign wr_active  = (state == S_RESTORE) && restore_ok;

   // next-state selection
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (bus.req_save)         state_nxt = S_SAVE;
               else if (bus.req_restore) state_nxt = S_RESTORE;
               else                      state_nxt = S_DONE;
            end
         end
         S_SAVE: begin
            if (save_last) state_nxt = restore_q ? S_RESTORE : S_DONE;
         end
         S_RESTORE: begin
            if (!restore_ok || (cnt == CNT_RESTORE_LAST)) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register and per-state cycle counter (cleared on every entry)
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)  cnt <= '0;
         else if (state != S_IDLE) cnt <= cnt + (RA_W+1)'(1);
      end
   end

   // request capture on acceptance; error latched when restore slot is empty
   always_ff @(posedge clk) begin
      if (rst) begin
         restore_q     <= 1'b0;
         save_tid_q    <= '0;
         restore_tid_q <= '0;
         err_q         <= 1'b0;
      end else if (accept) begin
         restore_q     <= bus.req_restore;
         save_tid_q    <= bus.req_save_tid;
         restore_tid_q <= bus.req_restore_tid;
         err_q         <= 1'b0;
      end else if ((state == S_RESTORE) && !restore_ok) begin
         err_q <= 1'b1;
      end
   end

   // slot valid bits: cleared when a save starts, set when it completes
   always_ff @(posedge clk) begin
      if (rst) begin
         ctx_valid_q <= '0;
      end else if (accept && bus.req_save) begin
         ctx_valid_q[bus.req_save_tid] <= 1'b0;
      end else if (save_last) begin
         ctx_valid_q[save_tid_q] <= 1'b1;
      end
   end

   // context store write port (contents are not reset; valid bits guard use)
   always_ff @(posedge clk) begin
      if (save_wr) store[save_tid_q][save_idx] <= bus.rf_rd_data;
   end

   // register-file and scheduler outputs; idle fields are held at zero
   always_comb begin
      bus.rf_rd_addr = '0;
      bus.rf_wr_en   = 1'b0;
      bus.rf_wr_addr = '0;
      bus.rf_wr_data = '0;
      if ((state == S_SAVE) && (cnt < CNT_SAVE_LAST)) bus.rf_rd_addr = cnt_lo;
      if (wr_active) begin
         bus.rf_wr_en   = 1'b1;
         bus.rf_wr_addr = cnt_lo;
         bus.rf_wr_data = store[restore_tid_q][cnt_lo];
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.err       = (state == S_DONE) && err_q;
   assign bus.ctx_valid = ctx_valid_q;

endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// Directed bench for ctx_switch_ctrl with a small behavioral register file.
module tb_ctx_switch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   ctx_switch_if #(.NUM_THREADS(4), .NUM_REGS(8), .DATA_W(32)) bus();

   ctx_switch_ctrl #(.NUM_THREADS(4), .NUM_REGS(8), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // register file model: 1-cycle read latency, preload port for setup
   logic [31:0] rf [8];
   logic        pre_en   = 1'b0;
   logic [31:0] pre_base = '0;
   logic [31:0] pre_step = '0;

   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < 8; i++) rf[i] <= pre_base + pre_step * 32'(i);
      end else if (bus.rf_wr_en) begin
         rf[bus.rf_wr_addr] <= bus.rf_wr_data;
      end
      bus.rf_rd_data <= rf[bus.rf_rd_addr];
   end

   // per-cycle trace of one request, index k = cycles after acceptance
   logic        acc_ready;
   logic        tr_done  [40];
   logic        tr_err   [40];
   logic        tr_wen   [40];
   logic        tr_ready [40];
   logic [2:0]  tr_raddr [40];
   logic [2:0]  tr_waddr [40];
   logic [31:0] tr_wdata [40];

   task automatic preload(input logic [31:0] base, input logic [31:0] step);
      @(negedge clk);
      pre_base = base;
      pre_step = step;
      pre_en   = 1'b1;
      @(negedge clk);
      pre_en   = 1'b0;
      @(negedge clk);
   endtask

   // issue one request and record ncyc cycles; fields are scrambled after
   // acceptance, valid optionally held, rst optionally pulsed at cycle rst_at
   task automatic run_req(input logic sv, input logic [1:0] st,
                          input logic rs, input logic [1:0] rt,
                          input int ncyc, input bit hold, input int rst_at);
      @(negedge clk);
      bus.req_save        = sv;
      bus.req_save_tid    = st;
      bus.req_restore     = rs;
      bus.req_restore_tid = rt;
      bus.req_valid       = 1'b1;
      acc_ready           = bus.req_ready;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         tr_done[k]  = bus.done;
         tr_err[k]   = bus.err;
         tr_wen[k]   = bus.rf_wr_en;
         tr_ready[k] = bus.req_ready;
         tr_raddr[k] = bus.rf_rd_addr;
         tr_waddr[k] = bus.rf_wr_addr;
         tr_wdata[k] = bus.rf_wr_data;
         bus.req_valid       = hold;
         bus.req_save        = ~sv;
         bus.req_save_tid    = ~st;
         bus.req_restore     = ~rs;
         bus.req_restore_tid = ~rt;
         rst = (k == rst_at);
      end
      bus.req_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({bus.req_ready, bus.busy, bus.done, bus.err} !== 4'b1000)
         $display("FAIL reset_status got %b exp 1000", {bus.req_ready, bus.busy, bus.done, bus.err});
      else n_pass++;
      n_chk++;
      if ({bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_addr, bus.rf_wr_data} !== 39'd0)
         $display("FAIL reset_rf_ports got %h exp 0", {bus.rf_wr_en, bus.rf_rd_addr, bus.rf_wr_addr, bus.rf_wr_data});
      else n_pass++;
      n_chk++;
      if (bus.ctx_valid !== 4'b0000)
         $display("FAIL reset_ctx_valid got %b exp 0000", bus.ctx_valid);
      else n_pass++;
   endtask

   task automatic test_save_only();
      logic [2:0] e_ra;
      preload(32'hA000_0000, 32'd1);
      run_req(1'b1, 2'd2, 1'b0, 2'd0, 11, 1'b0, 0);
      n_chk++;
      if (acc_ready !== 1'b1) $display("FAIL save_accept_ready got %b exp 1", acc_ready);
      else n_pass++;
      for (int k = 1; k <= 11; k++) begin
         e_ra = (k <= 8) ? 3'(k - 1) : 3'd0;
         n_chk++;
         if (tr_raddr[k] !== e_ra)
            $display("FAIL save_rd_addr k=%0d got %0d exp %0d", k, tr_raddr[k], e_ra);
         else n_pass++;
         n_chk++;
         if ({tr_done[k], tr_wen[k]} !== {(k == 10), 1'b0})
            $display("FAIL save_done_wen k=%0d got %b%b exp %b0", k, tr_done[k], tr_wen[k], (k == 10));
         else n_pass++;
      end
      n_chk++;
      if (tr_err[10] !== 1'b0) $display("FAIL save_err got %b exp 0", tr_err[10]);
      else n_pass++;
      n_chk++;
      if (bus.ctx_valid !== 4'b0100) $display("FAIL save_ctx_valid got %b exp 0100", bus.ctx_valid);
      else n_pass++;
   endtask

   task automatic test_restore_only();
      logic [31:0] e;
      preload(32'd0, 32'd0);
      run_req(1'b0, 2'd0, 1'b1, 2'd2, 10, 1'b0, 0);
      for (int k = 1; k <= 8; k++) begin
         e = 32'hA000_0000 + 32'(k - 1);
         n_chk++;
         if ({tr_wen[k], tr_waddr[k], tr_wdata[k]} !== {1'b1, 3'(k - 1), e})
            $display("FAIL restore_write k=%0d got %b/%0d/%h exp 1/%0d/%h",
                     k, tr_wen[k], tr_waddr[k], tr_wdata[k], k - 1, e);
         else n_pass++;
      end
      n_chk++;
      if ({tr_wen[9], tr_done[9], tr_err[9], tr_done[8]} !== 4'b0100)
         $display("FAIL restore_done got %b exp 0100", {tr_wen[9], tr_done[9], tr_err[9], tr_done[8]});
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         e = 32'hA000_0000 + 32'(i);
         n_chk++;
         if (rf[i] !== e) $display("FAIL restore_rf r%0d got %h exp %h", i, rf[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_restore_empty();
      run_req(1'b0, 2'd0, 1'b1, 2'd1, 3, 1'b0, 0);
      n_chk++;
      if ({tr_wen[1], tr_wen[2], tr_done[1]} !== 3'b000)
         $display("FAIL empty_no_write got %b exp 000", {tr_wen[1], tr_wen[2], tr_done[1]});
      else n_pass++;
      n_chk++;
      if ({tr_done[2], tr_err[2]} !== 2'b11)
         $display("FAIL empty_done_err got %b exp 11", {tr_done[2], tr_err[2]});
      else n_pass++;
      n_chk++;
      if (bus.ctx_valid !== 4'b0100) $display("FAIL empty_ctx_valid got %b exp 0100", bus.ctx_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      preload(32'hB000_0000, 32'd1);
      run_req(1'b1, 2'd0, 1'b1, 2'd2, 19, 1'b1, 0);
      for (int k = 1; k <= 8; k++) begin
         n_chk++;
         if ({tr_raddr[k], tr_wen[k]} !== {3'(k - 1), 1'b0})
            $display("FAIL b2b_read k=%0d got %0d/%b exp %0d/0", k, tr_raddr[k], tr_wen[k], k - 1);
         else n_pass++;
      end
      n_chk++;
      if (tr_wen[9] !== 1'b0) $display("FAIL b2b_gap_wen got %b exp 0", tr_wen[9]);
      else n_pass++;
      for (int k = 10; k <= 17; k++) begin
         e = 32'hA000_0000 + 32'(k - 10);
         n_chk++;
         if ({tr_wen[k], tr_waddr[k], tr_wdata[k]} !== {1'b1, 3'(k - 10), e})
            $display("FAIL b2b_write k=%0d got %b/%0d/%h exp 1/%0d/%h",
                     k, tr_wen[k], tr_waddr[k], tr_wdata[k], k - 10, e);
         else n_pass++;
      end
      n_chk++;
      if ({tr_done[17], tr_done[18], tr_err[18], tr_wen[18]} !== 4'b0100)
         $display("FAIL b2b_done got %b exp 0100", {tr_done[17], tr_done[18], tr_err[18], tr_wen[18]});
      else n_pass++;
      for (int k = 1; k <= 19; k++) begin
         n_chk++;
         if (tr_ready[k] !== (k == 19))
            $display("FAIL b2b_ready k=%0d got %b exp %b", k, tr_ready[k], (k == 19));
         else n_pass++;
      end
      n_chk++;
      if (bus.ctx_valid !== 4'b0101) $display("FAIL b2b_ctx_valid got %b exp 0101", bus.ctx_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid_save();
      run_req(1'b1, 2'd0, 1'b0, 2'd0, 8, 1'b0, 5);
      for (int k = 1; k <= 8; k++) begin
         n_chk++;
         if (tr_done[k] !== 1'b0) $display("FAIL rstmid_no_done k=%0d got %b exp 0", k, tr_done[k]);
         else n_pass++;
      end
      n_chk++;
      if ({tr_ready[5], tr_ready[6], tr_wen[6]} !== 3'b010)
         $display("FAIL rstmid_idle got %b exp 010", {tr_ready[5], tr_ready[6], tr_wen[6]});
      else n_pass++;
      n_chk++;
      if (bus.ctx_valid !== 4'b0000) $display("FAIL rstmid_ctx_valid got %b exp 0000", bus.ctx_valid);
      else n_pass++;
      run_req(1'b0, 2'd0, 1'b1, 2'd0, 3, 1'b0, 0);
      n_chk++;
      if ({tr_wen[1], tr_done[2], tr_err[2]} !== 3'b011)
         $display("FAIL rstmid_restore_err got %b exp 011", {tr_wen[1], tr_done[2], tr_err[2]});
      else n_pass++;
   endtask

   task automatic test_same_tid();
      logic [31:0] e;
      preload(32'hC000_0000, 32'd1);
      run_req(1'b1, 2'd3, 1'b1, 2'd3, 19, 1'b0, 0);
      for (int k = 10; k <= 17; k++) begin
         e = 32'hC000_0000 + 32'(k - 10);
         n_chk++;
         if ({tr_wen[k], tr_wdata[k]} !== {1'b1, e})
            $display("FAIL same_write k=%0d got %b/%h exp 1/%h", k, tr_wen[k], tr_wdata[k], e);
         else n_pass++;
      end
      n_chk++;
      if ({tr_done[18], tr_err[18]} !== 2'b10)
         $display("FAIL same_done got %b exp 10", {tr_done[18], tr_err[18]});
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         e = 32'hC000_0000 + 32'(i);
         n_chk++;
         if (rf[i] !== e) $display("FAIL same_rf r%0d got %h exp %h", i, rf[i], e);
         else n_pass++;
      end
      n_chk++;
      if (bus.ctx_valid !== 4'b1000) $display("FAIL same_ctx_valid got %b exp 1000", bus.ctx_valid);
      else n_pass++;
   endtask

   initial begin
      bus.req_valid       = 1'b0;
      bus.req_save        = 1'b0;
      bus.req_save_tid    = '0;
      bus.req_restore     = 1'b0;
      bus.req_restore_tid = '0;
      test_reset();
      test_save_only();
      test_restore_only();
      test_restore_empty();
      test_back_to_back();
      test_reset_mid_save();
      test_same_tid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
